// File: rtl/edu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : edu_pkg
// Brief    : Flit layout, FSM encodings and Hamming helpers for the EDU stage.
// Revision : 1.0
// ============================================================================
package edu_pkg;

    typedef struct packed {
        logic [6:0] data;
        logic [3:0] addr;
    } flit_t;

    localparam logic [0:0] c_IN_IDLE  = 1'b0;
    localparam logic [0:0] c_IN_ACK   = 1'b1;

    typedef enum logic [0:0] {
        IN_IDLE = c_IN_IDLE,
        IN_ACK  = c_IN_ACK
    } in_state_t;

    localparam logic [1:0] c_OUT_IDLE = 2'd0;
    localparam logic [1:0] c_OUT_REQ  = 2'd1;
    localparam logic [1:0] c_OUT_RTZ  = 2'd2;

    typedef enum logic [1:0] {
        OUT_IDLE = c_OUT_IDLE,
        OUT_REQ  = c_OUT_REQ,
        OUT_RTZ  = c_OUT_RTZ
    } out_state_t;

    function automatic logic [2:0] hamming_syndrome(input logic [6:0] data);
        logic p1, p2, p4;
        p1 = data[0] ^ data[2] ^ data[4] ^ data[6];
        p2 = data[1] ^ data[2] ^ data[5] ^ data[6];
        p4 = data[3] ^ data[4] ^ data[5] ^ data[6];
        return {p4, p2, p1};
    endfunction

    // Syndrome value s points at data bit s-1; zero means no flip.
    function automatic logic [6:0] hamming_correct(input logic [6:0] data, input logic [2:0] s);
        logic [6:0] mask;
        mask = '0;
        if (s != 3'd0) mask[s - 3'd1] = 1'b1;
        return data ^ mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/edu_fifo.sv
`default_nettype none
// ============================================================================
// Module   : edu_fifo
// Brief    : Synchronous FIFO; a pop in the same cycle frees room for a push.
// Revision : 1.0
// ============================================================================
module edu_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign o_full    = (r_count == (c_PTR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            unique case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/edu_hamming_stage.sv
`default_nettype none
// ============================================================================
// Module   : edu_hamming_stage
// Brief    : 4-phase in/out EDU: Hamming-correct, buffer and re-emit flits.
// Revision : 1.0
// ============================================================================
module edu_hamming_stage
    import edu_pkg::*;
#(
    parameter int WIDTH       = 11,
    parameter int DEPTH       = 2,
    parameter int SYNC_STAGES = 2,
    parameter int ECC_EN      = 1,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             in_req,
    output logic             in_ack,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_req,
    input  logic             out_ack,
    output logic [WIDTH-1:0] out_data,
    output logic             err_valid,
    output logic [2:0]       err_syndrome,
    output logic [CNT_W-1:0] corr_count
);

    logic [SYNC_STAGES-1:0] r_req_sync;
    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic                   w_req_s;
    logic                   w_ack_s;

    in_state_t  r_in_state,  w_in_state_next;
    out_state_t r_out_state, w_out_state_next;

    flit_t            w_in_flit;
    flit_t            w_push_flit;
    logic [2:0]       w_syn;
    logic [6:0]       w_fix_data;
    logic             w_push, w_pop, w_load, w_err, w_out_req_next;
    logic             w_fifo_full, w_fifo_empty;
    logic [WIDTH-1:0] w_fifo_head;

    logic             r_armed;
    logic             r_out_req;
    logic [WIDTH-1:0] r_out_data;
    logic             r_err_valid;
    logic [2:0]       r_err_syndrome;
    logic [CNT_W-1:0] r_corr_count;

    // Request sync resets high so a request still asserted across reset is
    // seen as busy until it has actually been observed low.
    generate
        if (SYNC_STAGES == 1) begin : g_sync_single
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    r_req_sync <= '1;
                    r_ack_sync <= '0;
                end else begin
                    r_req_sync <= in_req;
                    r_ack_sync <= out_ack;
                end
            end
        end else begin : g_sync_chain
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    r_req_sync <= '1;
                    r_ack_sync <= '0;
                end else begin
                    r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], in_req};
                    r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], out_ack};
                end
            end
        end
    endgenerate

    assign w_req_s = r_req_sync[SYNC_STAGES-1];
    assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

    assign w_in_flit   = in_data;
    assign w_syn       = hamming_syndrome(w_in_flit.data);
    assign w_fix_data  = (ECC_EN != 0) ? hamming_correct(w_in_flit.data, w_syn) : w_in_flit.data;
    assign w_push_flit = '{data: w_fix_data, addr: w_in_flit.addr};

    edu_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RESET),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_push_flit),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_head  (w_fifo_head)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_in_state  <= IN_IDLE;
            r_out_state <= OUT_IDLE;
        end else begin
            r_in_state  <= w_in_state_next;
            r_out_state <= w_out_state_next;
        end
    end

    always_comb begin
        w_in_state_next = r_in_state;
        unique case (r_in_state)
            IN_IDLE: if (w_push)   w_in_state_next = IN_ACK;
            IN_ACK:  if (!w_req_s) w_in_state_next = IN_IDLE;
            default:               w_in_state_next = IN_IDLE;
        endcase
    end

    always_comb begin
        w_out_state_next = r_out_state;
        unique case (r_out_state)
            OUT_IDLE: if (!w_fifo_empty) w_out_state_next = OUT_REQ;
            OUT_REQ:  if (w_ack_s)       w_out_state_next = OUT_RTZ;
            OUT_RTZ:  if (!w_ack_s)      w_out_state_next = OUT_IDLE;
            default:                     w_out_state_next = OUT_IDLE;
        endcase
    end

    // A pop in the same cycle lets a waiting push land on a full FIFO.
    always_comb begin
        w_load         = (r_out_state == OUT_IDLE) && !w_fifo_empty;
        w_pop          = (r_out_state == OUT_REQ) && w_ack_s;
        w_out_req_next = (r_out_state == OUT_REQ) && !w_ack_s;
        w_push         = (r_in_state == IN_IDLE) && w_req_s && r_armed && (!w_fifo_full || w_pop);
        w_err          = w_push && (w_syn != 3'd0);
        in_ack         = (r_in_state == IN_ACK);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_armed        <= 1'b0;
            r_out_req      <= 1'b0;
            r_out_data     <= '0;
            r_err_valid    <= 1'b0;
            r_err_syndrome <= '0;
            r_corr_count   <= '0;
        end else begin
            if (w_push)        r_armed <= 1'b0;
            else if (!w_req_s) r_armed <= 1'b1;
            if (w_load) r_out_data <= w_fifo_head;
            r_out_req   <= w_out_req_next;
            r_err_valid <= w_err;
            if (w_err) r_err_syndrome <= w_syn;
            if (w_err && (r_corr_count != {CNT_W{1'b1}}))
                r_corr_count <= r_corr_count + CNT_W'(1);
        end
    end

    assign out_req      = r_out_req;
    assign out_data     = r_out_data;
    assign err_valid    = r_err_valid;
    assign err_syndrome = r_err_syndrome;
    assign corr_count   = r_corr_count;

endmodule
`default_nettype wire

// File: tb/tb_edu_hamming_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_edu_hamming_stage
// Brief    : Randomized bench for edu_hamming_stage against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_edu_hamming_stage;

    localparam int c_SYNC = 2;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        in_req  = 1'b0;
    logic        out_ack = 1'b0;
    logic [10:0] in_data = '0;

    logic        in_ack, out_req, err_valid;
    logic [10:0] out_data;
    logic [2:0]  err_syndrome;
    logic [15:0] corr_count;

    logic        raw_in_ack, raw_out_req, raw_err_valid;
    logic [10:0] raw_out_data;
    logic [2:0]  raw_err_syndrome;
    logic [15:0] raw_corr_count;

    logic        sat_in_ack, sat_out_req, sat_err_valid;
    logic [10:0] sat_out_data;
    logic [2:0]  sat_err_syndrome;
    logic [1:0]  sat_corr_count;

    edu_hamming_stage #(.WIDTH(11), .DEPTH(2), .SYNC_STAGES(c_SYNC), .ECC_EN(1), .CNT_W(16)) u_dut (
        .CLK(clk), .RESET(rst), .in_req(in_req), .in_ack(in_ack), .in_data(in_data),
        .out_req(out_req), .out_ack(out_ack), .out_data(out_data), .err_valid(err_valid),
        .err_syndrome(err_syndrome), .corr_count(corr_count));

    edu_hamming_stage #(.WIDTH(11), .DEPTH(2), .SYNC_STAGES(c_SYNC), .ECC_EN(0), .CNT_W(16)) u_raw (
        .CLK(clk), .RESET(rst), .in_req(in_req), .in_ack(raw_in_ack), .in_data(in_data),
        .out_req(raw_out_req), .out_ack(out_ack), .out_data(raw_out_data), .err_valid(raw_err_valid),
        .err_syndrome(raw_err_syndrome), .corr_count(raw_corr_count));

    edu_hamming_stage #(.WIDTH(11), .DEPTH(2), .SYNC_STAGES(c_SYNC), .ECC_EN(1), .CNT_W(2)) u_sat (
        .CLK(clk), .RESET(rst), .in_req(in_req), .in_ack(sat_in_ack), .in_data(in_data),
        .out_req(sat_out_req), .out_ack(out_ack), .out_data(sat_out_data), .err_valid(sat_err_valid),
        .err_syndrome(sat_err_syndrome), .corr_count(sat_corr_count));

    always #5 clk = ~clk;

    int          n_vec       = 0;
    int          n_bad       = 0;
    int          n_corr      = 0;
    int          n_err_total = 0;
    int          n_pulses    = 0;
    bit          ds_hold     = 1'b0;
    logic [10:0] exp_q[$];
    logic [10:0] raw_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Syndrome = XOR of the 1-based positions of every set data bit.
    function automatic logic [2:0] ref_syn(input logic [6:0] d);
        int acc;
        acc = 0;
        for (int k = 0; k < 7; k++) if (d[k]) acc = acc ^ (k + 1);
        return acc[2:0];
    endfunction

    function automatic logic [10:0] ref_fix(input logic [10:0] f);
        logic [10:0] r;
        int          s;
        r = f;
        s = int'(ref_syn(f[10:4]));
        if (s != 0) r[3 + s] = ~r[3 + s];
        return r;
    endfunction

    always @(negedge clk) if (!rst && err_valid) n_pulses++;

    initial begin : downstream
        logic        prev_req;
        logic [10:0] prev_data;
        logic [10:0] e, r;
        prev_req  = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                out_ack = 1'b0;
            end else begin
                if (out_req && !prev_req) check_eq("data_setup", out_data, prev_data);
                if (!out_ack && out_req && !ds_hold && ($urandom_range(0, 2) != 0)) begin
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        r = raw_q.pop_front();
                    end else begin
                        e = 'x;
                        r = 'x;
                    end
                    check_eq("out_data", out_data, e);
                    check_eq("raw_out_data", raw_out_data, r);
                    out_ack = 1'b1;
                end else if (out_ack && !out_req) begin
                    out_ack = 1'b0;
                end
            end
            prev_req  = out_req;
            prev_data = out_data;
        end
    end

    task automatic send_flit(input logic [10:0] f, input bit blocked, input bit chk_lat);
        int         cyc;
        bit         seen;
        bit         prev_oreq;
        logic [2:0] s;
        s = ref_syn(f[10:4]);
        @(negedge clk);
        in_data = f;
        in_req  = 1'b1;
        if (blocked) begin
            repeat (8) @(negedge clk);
            check_eq("bp_no_ack", in_ack, 0);
            check_eq("bp_head_req", out_req, 1);
            ds_hold = 1'b0;
        end
        cyc       = 0;
        seen      = 1'b0;
        prev_oreq = out_req;
        while (!seen && cyc < 200) begin
            prev_oreq = out_req;
            @(negedge clk);
            cyc++;
            seen = in_ack;
        end
        check_eq("ack_seen", seen, 1);
        if (seen) begin
            if (chk_lat) check_eq("ack_latency", cyc, c_SYNC + 1);
            if (blocked) begin
                check_eq("pp_pop_same_cycle", out_req, 0);
                check_eq("pp_req_before", prev_oreq, 1);
            end
            exp_q.push_back(ref_fix(f));
            raw_q.push_back(f);
            if (s != 3'd0) begin
                n_corr++;
                n_err_total++;
            end
            check_eq("err_valid", err_valid, s != 3'd0);
            if (s != 3'd0) begin
                check_eq("err_syndrome", err_syndrome, s);
                check_eq("raw_err_syndrome", raw_err_syndrome, s);
            end
            check_eq("corr_count", corr_count, n_corr);
            check_eq("raw_corr_count", raw_corr_count, n_corr);
            check_eq("sat_corr_count", sat_corr_count, (n_corr > 3) ? 3 : n_corr);
            @(negedge clk);
            check_eq("err_pulse_width", err_valid, 0);
        end
        in_req = 1'b0;
        cyc = 0;
        while (in_ack && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("ack_rtz", in_ack, 0);
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || out_req || out_ack) && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("drain", exp_q.size(), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_in_ack", in_ack, 0);
        check_eq("rst_out_req", out_req, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_err_valid", err_valid, 0);
        check_eq("rst_corr_count", corr_count, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        send_flit(11'h556, 1'b0, 1'b1);
        drain();
        send_flit(11'h516, 1'b0, 1'b1);
        drain();

        ds_hold = 1'b1;
        send_flit(11'h516, 1'b0, 1'b1);
        send_flit(11'h1A3, 1'b0, 1'b0);
        send_flit(11'h556, 1'b1, 1'b0);
        drain();

        for (int i = 0; i < 40; i++) begin
            logic [10:0] f;
            f = 11'($urandom);
            if ($urandom_range(0, 3) == 0) f = ref_fix(f);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_flit(f, 1'b0, 1'b0);
        end
        drain();

        // Reset while a flit is presented downstream and in_ack is high.
        ds_hold = 1'b1;
        send_flit(11'h2B7, 1'b0, 1'b1);
        @(negedge clk);
        in_data = 11'h556;
        in_req  = 1'b1;
        for (int c = 0; c < 200 && !(in_ack && out_req); c++) @(negedge clk);
        check_eq("pre_rst_busy", in_ack && out_req, 1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_in_ack", in_ack, 0);
        check_eq("mid_rst_out_req", out_req, 0);
        check_eq("mid_rst_out_data", out_data, 0);
        check_eq("mid_rst_err_valid", err_valid, 0);
        check_eq("mid_rst_err_syndrome", err_syndrome, 0);
        check_eq("mid_rst_corr_count", corr_count, 0);
        check_eq("mid_rst_sat_count", sat_corr_count, 0);
        rst = 1'b0;
        exp_q.delete();
        raw_q.delete();
        n_corr = 0;
        repeat (10) @(negedge clk);
        check_eq("rst_held_req_ignored", in_ack, 0);
        check_eq("rst_fifo_empty", out_req, 0);
        in_req = 1'b0;
        repeat (6) @(negedge clk);
        ds_hold = 1'b0;
        send_flit(11'h516, 1'b0, 1'b1);
        drain();

        check_eq("err_pulse_total", n_pulses, n_err_total);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/edu_hamming_stage.md
Name: edu_hamming_stage

Overview:
- Synthesizable error-detection/correction unit (EDU) sitting directly upstream of the router path-computation stage.
- Accepts 11-bit flits {data[6:0], addr[3:0]} over a clocked 4-phase bundled-data handshake.
- Corrects single-bit errors in data[6:0] using the team Hamming syndrome, buffers flits in a small FIFO, and re-emits them on a 4-phase handshake to path computation.
- Keeps a saturating corrected-error counter.

Parameters:
- WIDTH, 11, flit width; data is [WIDTH-1:4] (7 bits), addr is [3:0].
- DEPTH, 2, FIFO entries; power of 2, minimum 2.
- SYNC_STAGES, 2, flops on in_req and out_ack before use; minimum 1.
- ECC_EN, 1, 1 = correct, 0 = pass-through (syndrome still reported).
- CNT_W, 16, corrected-error counter width.

Ports:
- CLK  in  1  single clock.
- RESET  in  1  synchronous, active-high reset.
- in_req  in  1  upstream 4-phase request.
- in_ack  out  1  upstream 4-phase acknowledge.
- in_data  in  WIDTH  bundled data; stable while in_req is high.
- out_req  out  1  downstream request.
- out_ack  in  1  downstream acknowledge.
- out_data  out  WIDTH  bundled data; registered.
- err_valid  out  1  one-cycle pulse when a nonzero syndrome is seen.
- err_syndrome  out  3  syndrome of the flit flagged by err_valid.
- corr_count  out  CNT_W  saturating count of nonzero syndromes.

Behaviour:
- Reset values: every output is 0. FIFO is emptied; both FSMs go to IDLE.
- Reset mid-handshake abandons the transfer. After RESET deasserts, upstream must return in_req low before a new transfer is recognised, because the input FSM waits in IDLE for a rising-level request.
- Syndrome, over data d[6:0]:
  - P1 = d0^d2^d4^d6
  - P2 = d1^d2^d5^d6
  - P4 = d3^d4^d5^d6
  - s = {P4, P2, P1}
  - If s != 0 and ECC_EN = 1, invert d[s-1]. Addr is never modified.
  - Correction is combinational on in_data at the capture cycle.
- Input FSM, states IN_IDLE and IN_ACK:
  - IN_IDLE: when synced in_req = 1 and the FIFO is not full → push the corrected flit, set in_ack = 1 on the next edge, go to IN_ACK. If the FIFO is full, stay in IN_IDLE with in_ack = 0 (backpressure).
  - IN_ACK: when synced in_req = 0 → in_ack = 0, go to IN_IDLE.
  - Latency: in_req rise to in_ack rise = SYNC_STAGES + 1 cycles.
- Output FSM, states OUT_IDLE, OUT_REQ and OUT_RTZ:
  - OUT_IDLE: when the FIFO is not empty → load out_data from the head, then set out_req = 1 one cycle later (data precedes request by ≥1 cycle). Go to OUT_REQ.
  - OUT_REQ: when synced out_ack = 1 → pop the FIFO, out_req = 0, go to OUT_RTZ.
  - OUT_RTZ: when synced out_ack = 0 → go to OUT_IDLE.
  - out_data holds until the next load.
- FIFO:
  - Push and pop in the same cycle are legal, including when full (the pop frees the slot, so the push succeeds) and when empty (no pop possible).
  - Pointers wrap modulo DEPTH; an occupancy counter of clog2(DEPTH)+1 bits disambiguates full from empty.
- Error reporting:
  - err_valid pulses for 1 cycle on each push with s != 0; err_syndrome is valid in that cycle.
  - corr_count increments on the same event (also when ECC_EN = 0) and saturates at all-ones with no wrap.
- Ordering: flits leave in arrival order; no drop or duplication.

Decomposition:
- Package edu_pkg:
  - typedef flit_t as a packed struct {logic [6:0] data; logic [3:0] addr;}
  - enums in_state_t and out_state_t
  - function hamming_syndrome(data) returning 3 bits
  - function hamming_correct(data, s)
- Sub-module edu_fifo: parameterized DEPTH/WIDTH synchronous FIFO with push, pop, full, empty, head.
- The top level contains the synchronizers, both FSMs and the counter.

Test Plan:
- Clean flit: in_data = 11'h556 (data 7'b1010101, addr 4'b0110) → out_data = 11'h556, err_valid never asserted, corr_count = 0, in_ack rises SYNC_STAGES+1 cycles after in_req.
- Single-bit error: in_data = 11'h516 (d2 flipped) → out_data = 11'h556, err_valid pulse with err_syndrome = 3'd3, corr_count = 1. With ECC_EN = 0: out_data = 11'h516, same syndrome and count.
- Backpressure: hold out_ack = 0, send 3 flits with DEPTH = 2 → first two acked. Third in_req is not acked while the FIFO is full (out_req is high for flit 1 but out_ack = 0, so nothing pops). On releasing out_ack, the third flit is acked and all three emerge in order.
- Simultaneous push/pop at full: FIFO full, third flit's in_req pending, downstream acks → pop and push occur in the same cycle, occupancy stays 2, no loss.
- Counter saturation with CNT_W = 2: send 5 erroneous flits → corr_count reads 1, 2, 3, 3, 3.
- Reset mid-operation: assert RESET while out_req = 1 and in_ack = 1 → next cycle all outputs are 0 and the FIFO is empty. A fresh flit after in_req returns low passes normally.
